irq_pending_ctrl: RTL and testbench



---
 rtl/irq_pending_ctrl.sv | 132 +++++++++++++
 tb/tb_irq_pending_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
//   Captures four asynchronous request lines and latches their rising edges
//   as pending bits. It drives the masked pending bits onto an external
//   4-input priority encoder and reads the encoder result back. It then
//   runs an IRQ/acknowledge handshake with the consumer and clears the
//   served pending bit when the consumer acknowledges.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   raw asynchronous requests (bit3=a ... bit0=d, a highest)
//   mask[3:0]  1 = source enabled; gates the pend_* outputs only
//   pend_a..d  masked pending bits, wired to encoder inputs a..d
//   enc_code   encoder index (3=a, 2=b, 1=c, 0=d)
//   enc_valid  encoder valid (any pend_* high)
//   irq        service request to the consumer
//   vec[1:0]   index of the source being served; stable while irq=1
//   ack        consumer acknowledge (level)
//   ovr[3:0]   sticky per-source overrun flags
//   clr_ovr    synchronous clear of all ovr bits
module irq_pending_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  output logic       pend_a,
  output logic       pend_b,
  output logic       pend_c,
  output logic       pend_d,
  input  logic [1:0] enc_code,
  input  logic       enc_valid,
  output logic       irq,
  output logic [1:0] vec,
  input  logic       ack,
  output logic [3:0] ovr,
  input  logic       clr_ovr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD
  } state_t;

  state_t     state;

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] prev;
  logic [3:0] pnd;
  logic [3:0] ovr_q;

  logic [3:0] rise;
  logic [3:0] clr_vec;
  logic [3:0] pnd_nxt;
  logic [3:0] ovr_set;
  logic [3:0] ovr_nxt;

  // The acknowledge clears only the bit being served. A new edge on the
  // same source in the same cycle wins, so that request is not lost.
  always_comb begin
    rise    = s2 & ~prev;
    clr_vec = '0;
    if (state == ST_ASSERT && ack) begin
      clr_vec = 4'b0001 << vec;
    end
    pnd_nxt = (pnd & ~clr_vec) | rise;
    // An edge on a bit that is still pending (and not being served away
    // this cycle) means an earlier request was merged: flag it. The set
    // beats a coincident clr_ovr.
    ovr_set = rise & pnd & ~clr_vec;
    ovr_nxt = ovr_set | (clr_ovr ? 4'b0000 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      pnd   <= '0;
      ovr_q <= '0;
    end else begin
      s1    <= req;
      s2    <= s1;
      prev  <= s2;
      pnd   <= pnd_nxt;
      ovr_q <= ovr_nxt;
    end
  end

  // vec is latched only on leaving IDLE, so mask/pend changes while a
  // source is being served cannot disturb the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
      vec   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            vec   <= enc_code;
            irq   <= 1'b1;
            state <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (ack) begin
            irq   <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!ack) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pend_a = pnd[3] & mask[3];
  assign pend_b = pnd[2] & mask[2];
  assign pend_c = pnd[1] & mask[1];
  assign pend_d = pnd[0] & mask[0];
  assign ovr    = ovr_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       pend_a, pend_b, pend_c, pend_d;
  logic [1:0] enc_code;
  logic       enc_valid;
  logic       irq;
  logic [1:0] vec;
  logic       ack;
  logic [3:0] ovr;
  logic       clr_ovr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External priority encoder that the block feeds.
  assign enc_valid = pend_a | pend_b | pend_c | pend_d;
  assign enc_code  = pend_a ? 2'd3 : pend_b ? 2'd2 : pend_c ? 2'd1 : 2'd0;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .pend_a    (pend_a),
    .pend_b    (pend_b),
    .pend_c    (pend_c),
    .pend_d    (pend_d),
    .enc_code  (enc_code),
    .enc_valid (enc_valid),
    .irq       (irq),
    .vec       (vec),
    .ack       (ack),
    .ovr       (ovr),
    .clr_ovr   (clr_ovr)
  );

  // Reference model: requests sampled at each edge kept in a history list.
  // A pending bit is set two edges after the first high sample of a line.
  logic [3:0] hist[$];
  logic [3:0] m_pnd;
  logic [3:0] m_ovr;
  logic [1:0] m_vec;
  logic       m_serving;
  logic       m_holding;

  function automatic logic [1:0] top_src(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_pnd     = '0;
    m_ovr     = '0;
    m_vec     = '0;
    m_serving = 1'b0;
    m_holding = 1'b0;
    hist.delete();
    repeat (3) hist.push_back(4'b0000);
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    logic [3:0] clr;
    logic       n_serving;
    logic       n_holding;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(req);
    if (hist.size() > 8) void'(hist.pop_front());
    rise      = hist[hist.size()-3] & ~hist[hist.size()-4];
    clr       = '0;
    n_serving = m_serving;
    n_holding = m_holding;
    if (m_serving) begin
      if (ack) begin
        clr       = 4'b0001 << m_vec;
        n_serving = 1'b0;
        n_holding = 1'b1;
      end
    end else if (m_holding) begin
      if (!ack) n_holding = 1'b0;
    end else if ((m_pnd & mask) != 4'b0000) begin
      m_vec     = top_src(m_pnd & mask);
      n_serving = 1'b1;
    end
    m_ovr     = (rise & m_pnd & ~clr) | (clr_ovr ? 4'b0000 : m_ovr);
    m_pnd     = (m_pnd & ~clr) | rise;
    m_serving = n_serving;
    m_holding = n_holding;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("irq",  {3'b000, irq}, {3'b000, m_serving});
    chk("vec",  {2'b00, vec}, {2'b00, m_vec});
    chk("pend", {pend_a, pend_b, pend_c, pend_d}, m_pnd & mask);
    chk("ovr",  ovr, m_ovr);
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 30; i++) begin
      if (m_serving) return;
      cycle();
    end
    if (!m_serving) chk("irq_timeout", {3'b000, irq}, 4'h1);
  endtask

  task automatic serve(input string tag, input logic [1:0] exp_vec);
    wait_irq();
    chk(tag, {2'b00, vec}, {2'b00, exp_vec});
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    mask    = 4'b1111;
    ack     = 1'b0;
    clr_ovr = 1'b0;
    model_reset();
    repeat (2) cycle();
    chk("rst_irq", {3'b000, irq}, 4'h0);
    chk("rst_ovr", ovr, 4'h0);

    // Requests held high through reset give one edge after release.
    req = 4'b1111;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_lat_irq", {3'b000, irq}, 4'h0);
    end
    chk("rst_lat_pend", {pend_a, pend_b, pend_c, pend_d}, 4'b1111);
    cycle();
    chk("rst_lat_irq_up", {3'b000, irq}, 4'h1);
    chk("rst_lat_vec", {2'b00, vec}, 4'h3);
    serve("serve_a", 2'd3);
    serve("serve_b", 2'd2);
    serve("serve_c", 2'd1);
    serve("serve_d", 2'd0);

    // Two simultaneous requests served in priority order.
    req = 4'b0000;
    repeat (3) cycle();
    req = 4'b0011;
    serve("pair_first", 2'd1);
    serve("pair_second", 2'd0);
    repeat (2) cycle();
    chk("pair_pend", {pend_a, pend_b, pend_c, pend_d}, 4'b0000);
    chk("pair_ovr", ovr, 4'b0000);

    // Higher-priority request during ASSERT must not change vec.
    req = 4'b0000;
    repeat (3) cycle();
    req = 4'b0010;
    wait_irq();
    req = 4'b1010;
    repeat (3) cycle();
    req = 4'b0010;
    chk("frozen_vec", {2'b00, vec}, 4'h1);
    chk("frozen_irq", {3'b000, irq}, 4'h1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    cycle();
    serve("after_hold", 2'd3);

    // Masked source stays latched and appears when unmasked.
    req = 4'b0000;
    repeat (3) cycle();
    mask = 4'b0111;
    req  = 4'b1000;
    repeat (5) cycle();
    chk("masked_pend_a", {3'b000, pend_a}, 4'h0);
    chk("masked_irq", {3'b000, irq}, 4'h0);
    mask = 4'b1111;
    repeat (2) cycle();
    chk("unmask_irq", {3'b000, irq}, 4'h1);
    chk("unmask_vec", {2'b00, vec}, 4'h3);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    req = 4'b0000;
    repeat (3) cycle();

    // Overrun on source b, clear, then set coinciding with clear.
    req = 4'b0100;
    repeat (2) cycle();
    req = 4'b0000;
    repeat (2) cycle();
    req = 4'b0100;
    repeat (2) cycle();
    req = 4'b0000;
    repeat (4) cycle();
    chk("ovr_set", ovr, 4'b0100);
    clr_ovr = 1'b1;
    cycle();
    clr_ovr = 1'b0;
    cycle();
    chk("ovr_clr", ovr, 4'b0000);
    req = 4'b0100;
    repeat (2) cycle();
    clr_ovr = 1'b1;
    cycle();
    clr_ovr = 1'b0;
    chk("ovr_beats_clr", ovr, 4'b0100);
    repeat (2) cycle();

    // Asynchronous reset mid-handshake, no clock edge needed.
    req = 4'b0000;
    wait_irq();
    chk("pre_rst_vec", {2'b00, vec}, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", {3'b000, irq}, 4'h0);
    chk("arst_vec", {2'b00, vec}, 4'h0);
    chk("arst_pend", {pend_a, pend_b, pend_c, pend_d}, 4'b0000);
    chk("arst_ovr", ovr, 4'b0000);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
      ack     = ($urandom_range(0, 2) == 0);
      clr_ovr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
